// File: rtl/atm_dispense_ctrl.sv
// Cash-dispense controller: plans a greedy 100/50/20/10 note breakdown against tracked
// cassette counts, then feeds notes one at a time over a feed/ack handshake.
`timescale 1ns/1ps
module atm_dispense_ctrl #(
    parameter int unsigned AMT_W   = 14,
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req,
    input  logic [AMT_W-1:0] amount,
    input  logic             load,
    input  logic [1:0]       load_denom,
    input  logic [CNT_W-1:0] load_count,
    input  logic             feed_ack,
    output logic             feed,
    output logic [1:0]       denom_sel,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [1:0]       err_code,
    output logic [AMT_W-1:0] dispensed,
    output logic [2:0]       state_display
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] ErrNone    = 2'd0;
    localparam logic [1:0] ErrBadAmt  = 2'd1;
    localparam logic [1:0] ErrNoNotes = 2'd2;
    localparam logic [1:0] ErrJam     = 2'd3;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StCheck   = 3'd1,
        StPlan    = 3'd2,
        StNext    = 3'd3,
        StFeed    = 3'd4,
        StWaitAck = 3'd5,
        StDone    = 3'd6,
        StError   = 3'd7
    } state_e;

    state_e                  state_q, state_d;
    logic [AMT_W-1:0]        amount_q, amount_d;
    logic [AMT_W-1:0]        rem_q, rem_d;
    logic [AMT_W-1:0]        dispensed_q, dispensed_d;
    logic [1:0]              d_q, d_d;
    logic [1:0]              err_code_q, err_code_d;
    logic [TMO_W-1:0]        tmo_q, tmo_d;
    logic [3:0][CNT_W-1:0]   count_q, count_d;
    logic [3:0][CNT_W-1:0]   planned_q, planned_d;

    function automatic logic [AMT_W-1:0] denom_val(input logic [1:0] idx);
        logic [AMT_W-1:0] v;
        case (idx)
            2'd0:    v = AMT_W'(100);
            2'd1:    v = AMT_W'(50);
            2'd2:    v = AMT_W'(20);
            default: v = AMT_W'(10);
        endcase
        return v;
    endfunction

    always_comb begin
        state_d     = state_q;
        amount_d    = amount_q;
        rem_d       = rem_q;
        dispensed_d = dispensed_q;
        d_d         = d_q;
        err_code_d  = err_code_q;
        tmo_d       = tmo_q;
        count_d     = count_q;
        planned_d   = planned_q;

        unique case (state_q)
            StIdle: begin
                if (load) begin
                    count_d[load_denom] = load_count;
                end
                if (req) begin
                    amount_d    = amount;
                    dispensed_d = '0;
                    err_code_d  = ErrNone;
                    planned_d   = '0;
                    state_d     = StCheck;
                end
            end
            StCheck: begin
                if (amount_q == '0 || (amount_q % AMT_W'(10)) != '0) begin
                    err_code_d = ErrBadAmt;
                    state_d    = StError;
                end else begin
                    rem_d   = amount_q;
                    d_d     = 2'd0;
                    state_d = StPlan;
                end
            end
            StPlan: begin
                if (rem_q >= denom_val(d_q) && planned_q[d_q] < count_q[d_q]) begin
                    planned_d[d_q] = planned_q[d_q] + CNT_W'(1);
                    rem_d          = rem_q - denom_val(d_q);
                end else if (d_q != 2'd3) begin
                    d_d = d_q + 2'd1;
                end else if (rem_q == '0) begin
                    d_d     = 2'd0;
                    state_d = StNext;
                end else begin
                    err_code_d = ErrNoNotes;
                    state_d    = StError;
                end
            end
            StNext: begin
                if (planned_q[d_q] != '0) begin
                    state_d = StFeed;
                end else if (d_q != 2'd3) begin
                    d_d = d_q + 2'd1;
                end else begin
                    state_d = StDone;
                end
            end
            StFeed: begin
                tmo_d   = '0;
                state_d = StWaitAck;
            end
            StWaitAck: begin
                if (feed_ack) begin
                    // planned <= count holds from PLAN, so this cannot underflow
                    count_d[d_q]   = count_q[d_q] - CNT_W'(1);
                    planned_d[d_q] = planned_q[d_q] - CNT_W'(1);
                    dispensed_d    = dispensed_q + denom_val(d_q);
                    state_d        = StNext;
                end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                    err_code_d = ErrJam;
                    state_d    = StError;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            StDone:  state_d = StIdle;
            StError: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            amount_q    <= '0;
            rem_q       <= '0;
            dispensed_q <= '0;
            d_q         <= 2'd0;
            err_code_q  <= ErrNone;
            tmo_q       <= '0;
            count_q     <= '0;
            planned_q   <= '0;
        end else begin
            amount_q    <= amount_d;
            rem_q       <= rem_d;
            dispensed_q <= dispensed_d;
            d_q         <= d_d;
            err_code_q  <= err_code_d;
            tmo_q       <= tmo_d;
            count_q     <= count_d;
            planned_q   <= planned_d;
        end
    end

    assign feed          = (state_q == StFeed);
    assign denom_sel     = d_q;
    assign busy          = (state_q != StIdle);
    assign done          = (state_q == StDone);
    assign error         = (state_q == StError);
    assign err_code      = err_code_q;
    assign dispensed     = dispensed_q;
    assign state_display = state_q;

endmodule

// File: tb/tb_atm_dispense_ctrl.sv
// Directed bench for atm_dispense_ctrl: models the note-feed mechanism and checks
// breakdown order, totals, cassette bookkeeping and the three error paths.
`timescale 1ns/1ps
module tb_atm_dispense_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic [13:0] amount;
    logic        load;
    logic [1:0]  load_denom;
    logic [7:0]  load_count;
    logic        feed_ack;
    logic        feed;
    logic [1:0]  denom_sel;
    logic        busy;
    logic        done;
    logic        error;
    logic [1:0]  err_code;
    logic [13:0] dispensed;
    logic [2:0]  state_display;

    int checks = 0;
    int errors = 0;

    // Results of the last run_txn
    int          n_feeds;
    logic [15:0] seq;
    bit          got_done;
    bit          got_error;
    int          last_wait;
    int          n_cyc;
    bit          busy_after_req;

    atm_dispense_ctrl #(
        .AMT_W  (14),
        .CNT_W  (8),
        .TIMEOUT(16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .amount       (amount),
        .load         (load),
        .load_denom   (load_denom),
        .load_count   (load_count),
        .feed_ack     (feed_ack),
        .feed         (feed),
        .denom_sel    (denom_sel),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .err_code     (err_code),
        .dispensed    (dispensed),
        .state_display(state_display)
    );

    always #5 clk = ~clk;

    task automatic load_cassettes(input logic [7:0] c0, input logic [7:0] c1,
                                  input logic [7:0] c2, input logic [7:0] c3);
        logic [7:0] c [4];
        c[0] = c0; c[1] = c1; c[2] = c2; c[3] = c3;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            load = 1'b1; load_denom = 2'(i); load_count = c[i];
        end
        @(negedge clk);
        load = 1'b0;
    endtask

    // Issues one request and plays the mechanism: acks each note on its ack_delay-th
    // WAIT_ACK cycle, up to ack_limit notes. disturb injects inputs that must be ignored.
    task automatic run_txn(input logic [13:0] amt, input int ack_delay, input int ack_limit,
                           input bit disturb);
        int wa;
        int acked;
        n_feeds = 0; seq = '0; got_done = 0; got_error = 0; last_wait = 0; n_cyc = 0;
        wa = 0; acked = 0;
        @(negedge clk);
        req = 1'b1; amount = amt;
        @(negedge clk);
        req = 1'b0;
        busy_after_req = busy;
        for (int cyc = 0; cyc < 400; cyc++) begin
            feed_ack = 1'b0; req = 1'b0; load = 1'b0;
            n_cyc = cyc;
            if (done) begin got_done = 1; break; end
            if (error) begin got_error = 1; break; end
            if (feed) begin
                if (n_feeds < 8) seq[2*n_feeds +: 2] = denom_sel;
                n_feeds++;
                wa = 0;
                if (disturb) feed_ack = 1'b1;
            end else if (state_display == 3'd5) begin
                wa++;
                last_wait = wa;
                if (acked < ack_limit && wa == ack_delay) begin
                    feed_ack = 1'b1;
                    acked++;
                end
                if (disturb && wa == 1) begin
                    req = 1'b1; amount = 14'd10;
                    load = 1'b1; load_denom = 2'd3; load_count = 8'd50;
                end
            end
            @(negedge clk);
        end
        feed_ack = 1'b0; req = 1'b0; load = 1'b0;
        checks++;
        if (!got_done && !got_error) begin
            errors++;
            $display("FAIL txn_terminates: amount %0d got no done/error within 400 cycles", amt);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = 0; amount = '0; load = 0; load_denom = '0; load_count = '0;
        feed_ack = 0;
        #12;
        checks++;
        if ({state_display, feed, done, error, busy, denom_sel, err_code} !== 10'd0) begin
            errors++;
            $display("FAIL reset_outputs: got st=%0d feed=%0b done=%0b err=%0b busy=%0b ds=%0d ec=%0d expected all 0",
                     state_display, feed, done, error, busy, denom_sel, err_code);
        end
        checks++;
        if (dispensed !== 14'd0 || dut.count_q !== 32'd0 || dut.planned_q !== 32'd0) begin
            errors++;
            $display("FAIL reset_regs: dispensed=%0d counts=%h planned=%h expected 0",
                     dispensed, dut.count_q, dut.planned_q);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_dispense();
        load_cassettes(8'd10, 8'd10, 8'd10, 8'd10);
        run_txn(14'd380, 2, 100, 1'b0);
        checks++;
        if (busy_after_req !== 1'b1) begin
            errors++; $display("FAIL busy_rise: got %0b expected 1", busy_after_req);
        end
        checks++;
        if (!got_done || n_feeds != 6) begin
            errors++; $display("FAIL disp380_done: done=%0b feeds=%0d expected 1 and 6", got_done, n_feeds);
        end
        checks++;
        if (seq !== 16'h0E40) begin
            errors++; $display("FAIL disp380_order: got %h expected 0e40", seq);
        end
        checks++;
        if (dispensed !== 14'd380 || err_code !== 2'd0) begin
            errors++; $display("FAIL disp380_total: dispensed=%0d ec=%0d expected 380 and 0", dispensed, err_code);
        end
        checks++;
        if (dut.count_q !== {8'd9, 8'd9, 8'd9, 8'd7}) begin
            errors++; $display("FAIL disp380_counts: got %h expected 09090907", dut.count_q);
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL busy_in_done: got %0b expected 1", busy);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || dispensed !== 14'd380) begin
            errors++;
            $display("FAIL after_done: busy=%0b done=%0b dispensed=%0d expected 0 0 380", busy, done, dispensed);
        end
    endtask

    task automatic test_bad_amount();
        logic [13:0] amts [2];
        amts[0] = 14'd125; amts[1] = 14'd0;
        for (int i = 0; i < 2; i++) begin
            run_txn(amts[i], 2, 100, 1'b0);
            checks++;
            if (!got_error || n_cyc != 1 || n_feeds != 0) begin
                errors++;
                $display("FAIL bad_amt_%0d: error=%0b cycle=%0d feeds=%0d expected 1 1 0",
                         amts[i], got_error, n_cyc, n_feeds);
            end
            checks++;
            if (err_code !== 2'd1 || dispensed !== 14'd0) begin
                errors++;
                $display("FAIL bad_amt_code_%0d: ec=%0d dispensed=%0d expected 1 0", amts[i], err_code, dispensed);
            end
        end
        @(negedge clk);
        checks++;
        if (err_code !== 2'd1 || busy !== 1'b0) begin
            errors++; $display("FAIL err_code_hold: ec=%0d busy=%0b expected 1 0", err_code, busy);
        end
    endtask

    task automatic test_no_notes();
        load_cassettes(8'd0, 8'd1, 8'd0, 8'd0);
        run_txn(14'd60, 2, 100, 1'b0);
        checks++;
        if (!got_error || err_code !== 2'd2 || n_feeds != 0) begin
            errors++;
            $display("FAIL no_notes: error=%0b ec=%0d feeds=%0d expected 1 2 0", got_error, err_code, n_feeds);
        end
        checks++;
        if (dut.count_q !== {8'd0, 8'd0, 8'd1, 8'd0} || dispensed !== 14'd0) begin
            errors++;
            $display("FAIL no_notes_counts: counts=%h dispensed=%0d expected 00000100 0", dut.count_q, dispensed);
        end
    endtask

    task automatic test_jam();
        load_cassettes(8'd10, 8'd0, 8'd0, 8'd0);
        run_txn(14'd200, 2, 1, 1'b0);
        checks++;
        if (!got_error || err_code !== 2'd3 || n_feeds != 2) begin
            errors++;
            $display("FAIL jam: error=%0b ec=%0d feeds=%0d expected 1 3 2", got_error, err_code, n_feeds);
        end
        checks++;
        if (last_wait != 16) begin
            errors++; $display("FAIL jam_timeout: waited %0d expected 16", last_wait);
        end
        checks++;
        if (dispensed !== 14'd100 || dut.count_q[0] !== 8'd9) begin
            errors++;
            $display("FAIL jam_partial: dispensed=%0d count0=%0d expected 100 9", dispensed, dut.count_q[0]);
        end
    endtask

    task automatic test_ignored_inputs();
        load_cassettes(8'd7, 8'd9, 8'd9, 8'd9);
        run_txn(14'd30, 2, 100, 1'b1);
        checks++;
        if (!got_done || seq !== 16'h000E || n_feeds != 2) begin
            errors++;
            $display("FAIL ignore_flow: done=%0b seq=%h feeds=%0d expected 1 000e 2", got_done, seq, n_feeds);
        end
        checks++;
        if (dispensed !== 14'd30 || dut.count_q !== {8'd8, 8'd8, 8'd9, 8'd7}) begin
            errors++;
            $display("FAIL ignore_state: dispensed=%0d counts=%h expected 30 08080907", dispensed, dut.count_q);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL ignore_req_dropped: busy=%0b expected 0", busy);
        end
    endtask

    task automatic test_mid_reset();
        bit reached;
        load_cassettes(8'd1, 8'd0, 8'd0, 8'd0);
        @(negedge clk);
        req = 1'b1; amount = 14'd100;
        @(negedge clk);
        req = 1'b0;
        reached = 0;
        for (int i = 0; i < 20; i++) begin
            if (state_display == 3'd5) begin reached = 1; break; end
            @(negedge clk);
        end
        checks++;
        if (!reached) begin
            errors++; $display("FAIL mid_reset_reach: WAIT_ACK not reached expected within 20 cycles");
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (state_display !== 3'd0 || feed !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_state: st=%0d feed=%0b busy=%0b expected 0 0 0", state_display, feed, busy);
        end
        checks++;
        if (dut.count_q !== 32'd0 || dispensed !== 14'd0) begin
            errors++;
            $display("FAIL mid_reset_regs: counts=%h dispensed=%0d expected 0 0", dut.count_q, dispensed);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_dispense();
        test_bad_amount();
        test_no_notes();
        test_jam();
        test_ignored_inputs();
        test_mid_reset();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
